// File: rtl/fsm2s.sv
// Two-state Moore flag: j sets it from OFF to ON, k clears it from ON to OFF.
// The output is decoded from the state register only.
module fsm2s (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic out
);

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next;

  // Active-low reset acts immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= OFF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OFF:     if (j) w_next = ON;
      ON:      if (k) w_next = OFF;
      default: w_next = OFF;
    endcase
  end

  assign out = (r_state == ON);

endmodule

// File: tb/tb_fsm2s.sv
// Directed and model-based checks for the fsm2s J/K flag.
// Inputs change on the falling clock edge; out is sampled 1 time unit after the rising edge.
module tb_fsm2s;

  logic clk;
  logic reset;
  logic j;
  logic k;
  logic out;

  int checks;
  int errors;
  logic model;

  logic [1:0] seqKj  [12];
  logic       seqOut [12];

  fsm2s dut (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: out=%b required=%b at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Drive j/k on the falling edge, then wait for the rising edge plus 1.
  task automatic applyStimulus(input logic jIn, input logic kIn);
    @(negedge clk);
    j = jIn;
    k = kIn;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    j      = 1'b0;
    k      = 1'b0;
    #1;
    checkOutput("reset_state", out, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // The first edge after reset release applies the normal OFF rule.
    applyStimulus(1'b1, 1'b0);
    checkOutput("release_set", out, 1'b1);

    // Asynchronous reset while ON.
    @(negedge clk);
    j = 1'b1;
    k = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_drop", out, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("reset_hold", out, 1'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    j     = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_j0", out, 1'b0);

    // Set and hold.
    applyStimulus(1'b1, 1'b0);
    checkOutput("set", out, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("hold_on", out, 1'b1);
    end

    // Clear, then k and j=k=0 in OFF.
    applyStimulus(1'b1, 1'b1);
    checkOutput("clear_jk", out, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("k_in_off", out, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("hold_off", out, 1'b0);

    // Toggle with j=k=1.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("toggle", out, (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Directed {k,j} sequence starting from OFF.
    seqKj  = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10,
               2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
    seqOut = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(seqKj[i][0], seqKj[i][1]);
      checkOutput("sequence", out, seqOut[i]);
    end

    // Random j/k with occasional reset pulses against a behavioral model.
    model = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      checkOutput("rand_neg", out, model);
      j     = 1'($urandom_range(1));
      k     = 1'($urandom_range(1));
      reset = ($urandom_range(7) == 0) ? 1'b0 : 1'b1;
      if (!reset) begin
        model = 1'b0;
        #1;
        checkOutput("rand_rst", out, model);
      end
      @(posedge clk);
      if (reset) model = model ? ~k : j;
      #1;
      checkOutput("rand_pos", out, model);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
